// File: rtl/fib_step_sequencer_pkg.sv
// Shared definitions for the Fibonacci sequencer and the Wishbone register
// block: state encodings, default widths and the interrupt bit position.
// No ports.
package fib_step_sequencer_pkg;

    localparam int CLOCK_WIDTH_DEF = 6;
    localparam int VALUE_WIDTH_DEF = 30;
    localparam int COUNT_WIDTH_DEF = 16;

    // Bit position of the wrap interrupt inside the interrupt status register.
    localparam int IRQ_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_HALT  = 3'd4
    } fib_state_t;

endpackage

// File: rtl/fib_step_sequencer_tick_divider.sv
// Step-period down-counter.
//   wb_clk_i  in   clock
//   reset     in   asynchronous active-high reset (count -> 0)
//   load      in   reload the counter from period
//   run       in   count down; reloads from period when it expires
//   period    in   step period in cycles; 0 behaves as 1
//   expired   out  counter is at zero
module fib_step_sequencer_tick_divider #(
    parameter int WIDTH = 6
) (
    input  logic             wb_clk_i,
    input  logic             reset,
    input  logic             load,
    input  logic             run,
    input  logic [WIDTH-1:0] period,
    output logic             expired
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload_val;

    // max(period,1)-1: a period of 0 reloads to 0 just like a period of 1.
    assign reload_val = (period == '0) ? '0 : period - WIDTH'(1);
    assign expired    = (count == '0);

    always_ff @(posedge wb_clk_i or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load || (run && expired)) begin
            count <= reload_val;
        end else if (run) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/fib_step_sequencer.sv
// Fibonacci step sequencer: turns the control-register switch, step period
// and panic flag into step/clear strobes for the Fibonacci core, watches the
// core output for numeric wrap and raises a sticky interrupt.
//   wb_clk_i      in   clock
//   reset         in   asynchronous active-high reset
//   switch_in     in   1 = run, 0 = stop
//   clock_op      in   step period in cycles (0 behaves as 1)
//   panic_in      in   freeze until reset
//   fib_value     in   core output, valid the cycle after step_o
//   irq_clr_in    in   clears irq_o
//   step_o        out  core advances one term
//   clear_o       out  core reloads its 0,1 seed
//   busy_o        out  in CLEAR, RUN or CHECK
//   halted_o      out  in HALT
//   irq_o         out  sticky wrap interrupt
//   step_count_o  out  saturating steps since last clear
//
// state | meaning
// IDLE  | stopped, waiting for switch_in
// CLEAR | reseeding the core, reloading the divider
// RUN   | counting down to the next step
// CHECK | core output of the last step is compared for wrap
// HALT  | panic seen; left only by reset
module fib_step_sequencer
    import fib_step_sequencer_pkg::*;
#(
    parameter int CLOCK_WIDTH = CLOCK_WIDTH_DEF,
    parameter int VALUE_WIDTH = VALUE_WIDTH_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                   wb_clk_i,
    input  logic                   reset,
    input  logic                   switch_in,
    input  logic [CLOCK_WIDTH-1:0] clock_op,
    input  logic                   panic_in,
    input  logic [VALUE_WIDTH-1:0] fib_value,
    input  logic                   irq_clr_in,
    output logic                   step_o,
    output logic                   clear_o,
    output logic                   busy_o,
    output logic                   halted_o,
    output logic                   irq_o,
    output logic [COUNT_WIDTH-1:0] step_count_o
);

    fib_state_t             state;
    logic [VALUE_WIDTH-1:0] prev_value;
    logic [IRQ_BIT:0]       irq_q;
    logic                   expired;
    logic                   active;
    logic                   wrap;
    logic                   wrap_hit;

    // Panic and a dropped switch pre-empt everything in the same cycle, so
    // the strobes are qualified by the live inputs rather than registered.
    assign active   = switch_in & ~panic_in;
    assign wrap     = (fib_value < prev_value);
    assign wrap_hit = active & (state == ST_CHECK) & wrap;
    assign step_o   = active & expired &
                      ((state == ST_RUN) | ((state == ST_CHECK) & ~wrap));
    assign clear_o  = active & (state == ST_CLEAR);
    assign busy_o   = (state == ST_CLEAR) | (state == ST_RUN) | (state == ST_CHECK);
    assign halted_o = (state == ST_HALT);
    assign irq_o    = irq_q[IRQ_BIT];

    fib_step_sequencer_tick_divider #(
        .WIDTH (CLOCK_WIDTH)
    ) u_divider (
        .wb_clk_i (wb_clk_i),
        .reset    (reset),
        .load     (state == ST_CLEAR),
        .run      ((state == ST_RUN) || (state == ST_CHECK)),
        .period   (clock_op),
        .expired  (expired)
    );

    always_ff @(posedge wb_clk_i or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            prev_value   <= '0;
            irq_q        <= '0;
            step_count_o <= '0;
        end else begin
            // Set beats a simultaneous clear.
            if (wrap_hit) begin
                irq_q[IRQ_BIT] <= 1'b1;
            end else if (irq_clr_in) begin
                irq_q[IRQ_BIT] <= 1'b0;
            end

            if (step_o && (step_count_o != '1)) begin
                step_count_o <= step_count_o + COUNT_WIDTH'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (panic_in) begin
                        state <= ST_HALT;
                    end else if (switch_in) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (panic_in) begin
                        state <= ST_HALT;
                    end else if (!switch_in) begin
                        state <= ST_IDLE;
                    end else begin
                        step_count_o <= '0;
                        prev_value   <= '0;
                        state        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (panic_in) begin
                        state <= ST_HALT;
                    end else if (!switch_in) begin
                        state <= ST_IDLE;
                    end else if (expired) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (panic_in) begin
                        state <= ST_HALT;
                    end else if (!switch_in) begin
                        state <= ST_IDLE;
                    end else if (wrap) begin
                        state <= ST_CLEAR;
                    end else begin
                        prev_value <= fib_value;
                        // Stay in CHECK when this cycle stepped again.
                        if (!expired) begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_step_sequencer.sv
module tb_fib_step_sequencer;

    logic        wb_clk_i = 1'b0;
    logic        reset;
    logic        switch_in;
    logic [5:0]  clock_op;
    logic        panic_in;
    logic [29:0] fib_value;
    logic        irq_clr_in;
    logic        step_o;
    logic        clear_o;
    logic        busy_o;
    logic        halted_o;
    logic        irq_o;
    logic [15:0] step_count_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] sm;
    logic [63:0] cm;

    always #5 wb_clk_i = ~wb_clk_i;

    fib_step_sequencer dut (
        .wb_clk_i     (wb_clk_i),
        .reset        (reset),
        .switch_in    (switch_in),
        .clock_op     (clock_op),
        .panic_in     (panic_in),
        .fib_value    (fib_value),
        .irq_clr_in   (irq_clr_in),
        .step_o       (step_o),
        .clear_o      (clear_o),
        .busy_o       (busy_o),
        .halted_o     (halted_o),
        .irq_o        (irq_o),
        .step_count_o (step_count_o)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge wb_clk_i);
        #2;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        switch_in  = 1'b0;
        panic_in   = 1'b0;
        irq_clr_in = 1'b0;
        clock_op   = 6'd0;
        fib_value  = 30'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Bit i of the masks = strobe seen in cycle i (inputs held constant).
    task automatic run_cycles(input int n, output logic [63:0] s_mask, output logic [63:0] c_mask);
        s_mask = '0;
        c_mask = '0;
        for (int i = 0; i < n; i++) begin
            #1;
            s_mask[i] = step_o;
            c_mask[i] = clear_o;
            tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".step"},   step_o,       0);
        check_val({tag, ".clear"},  clear_o,      0);
        check_val({tag, ".busy"},   busy_o,       0);
        check_val({tag, ".halted"}, halted_o,     0);
        check_val({tag, ".irq"},    irq_o,        0);
        check_val({tag, ".count"},  step_count_o, 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        check_all_zero("rst");
        tick();

        // Period 4 for 20 cycles
        clock_op  = 6'd4;
        switch_in = 1'b1;
        run_cycles(20, sm, cm);
        check_val("p4.steps",  sm, 64'h22220);
        check_val("p4.clears", cm, 64'h2);
        #1;
        check_val("p4.count", step_count_o, 16'd4);
        check_val("p4.busy",  busy_o, 1);
        switch_in = 1'b0;
        tick();
        #1;
        check_val("p4.off_busy",  busy_o, 0);
        check_val("p4.off_count", step_count_o, 16'd4);
        tick();

        // Async reset mid-RUN with divider at 3
        do_reset();
        clock_op  = 6'd4;
        switch_in = 1'b1;
        run_cycles(2, sm, cm);
        #1;
        check_val("mid.busy_before", busy_o, 1);
        reset = 1'b1;
        #1;
        check_all_zero("mid");
        tick();
        reset = 1'b0;
        run_cycles(8, sm, cm);
        check_val("mid.steps",  sm, 64'h20);
        check_val("mid.clears", cm, 64'h2);

        // clock_op = 0 steps every cycle
        do_reset();
        clock_op  = 6'd0;
        switch_in = 1'b1;
        run_cycles(8, sm, cm);
        check_val("p0.steps",  sm, 64'hFC);
        check_val("p0.clears", cm, 64'h2);

        // Period change 2 -> 5 takes effect at the next reload
        do_reset();
        clock_op  = 6'd2;
        switch_in = 1'b1;
        run_cycles(6, sm, cm);
        check_val("chg.steps_a",  sm, 64'h28);
        check_val("chg.clears_a", cm, 64'h2);
        clock_op = 6'd5;
        run_cycles(14, sm, cm);
        check_val("chg.steps_b",  sm, 64'h842);
        check_val("chg.clears_b", cm, 64'h0);

        // Wrap detection: 10 then 3
        do_reset();
        clock_op  = 6'd4;
        switch_in = 1'b1;
        sm = '0;
        cm = '0;
        for (int c = 0; c < 13; c++) begin
            fib_value = (c >= 10) ? 30'd3 : ((c >= 6) ? 30'd10 : 30'd0);
            #1;
            sm[c] = step_o;
            cm[c] = clear_o;
            if (c == 10) check_val("wrap.count_before", step_count_o, 16'd2);
            if (c == 11) check_val("wrap.irq_set", irq_o, 1);
            if (c == 12) begin
                check_val("wrap.count_after", step_count_o, 16'd0);
                check_val("wrap.irq_sticky", irq_o, 1);
            end
            tick();
        end
        check_val("wrap.steps",  sm, 64'h220);
        check_val("wrap.clears", cm, 64'h802);
        irq_clr_in = 1'b1;
        tick();
        irq_clr_in = 1'b0;
        #1;
        check_val("wrap.irq_cleared", irq_o, 0);
        tick();

        // Expiry, switch off and panic in the same cycle
        do_reset();
        clock_op  = 6'd4;
        switch_in = 1'b1;
        run_cycles(5, sm, cm);
        #1;
        check_val("pan.step_pending", step_o, 1);
        switch_in = 1'b0;
        panic_in  = 1'b1;
        #1;
        check_val("pan.step_dropped", step_o, 0);
        check_val("pan.clear", clear_o, 0);
        tick();
        #1;
        check_val("pan.halted", halted_o, 1);
        check_val("pan.busy",   busy_o, 0);
        panic_in  = 1'b0;
        switch_in = 1'b1;
        run_cycles(3, sm, cm);
        switch_in = 1'b0;
        run_cycles(2, sm, cm);
        switch_in = 1'b1;
        run_cycles(4, sm, cm);
        check_val("pan.steps_after",  sm, 64'h0);
        check_val("pan.clears_after", cm, 64'h0);
        #1;
        check_val("pan.still_halted", halted_o, 1);
        tick();

        // Wrap and irq clear in the same cycle
        do_reset();
        clock_op  = 6'd2;
        switch_in = 1'b1;
        sm = '0;
        cm = '0;
        for (int c = 0; c < 8; c++) begin
            fib_value  = (c >= 6) ? 30'd3 : ((c >= 4) ? 30'd10 : 30'd0);
            irq_clr_in = (c == 6);
            #1;
            sm[c] = step_o;
            cm[c] = clear_o;
            if (c == 7) check_val("both.irq", irq_o, 1);
            tick();
        end
        irq_clr_in = 1'b0;
        check_val("both.steps",  sm, 64'h28);
        check_val("both.clears", cm, 64'h82);

        // Step counter saturation
        do_reset();
        clock_op  = 6'd1;
        switch_in = 1'b1;
        for (int c = 0; c < 102; c++) tick();
        #1;
        check_val("sat.count_100", step_count_o, 16'd100);
        for (int c = 0; c < 65540; c++) tick();
        #1;
        check_val("sat.count_max", step_count_o, 16'hFFFF);
        check_val("sat.busy", busy_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
